// File: rtl/mm_bridge_pkg.sv
// Shared types and bridge BRAM address map for the Montgomery host bridge.
// Holds the FSM state enum, section width and address helpers.
package mm_bridge_pkg;

  localparam int SEC_W = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_FLUSH
  } state_t;

  localparam int unsigned P_PRIME_0_ADDR = 0;
  localparam int unsigned P_BASE         = 1;
  // The multiplier writes its result over the consumed p region.
  localparam int unsigned RES_BASE       = P_BASE;

  function automatic int unsigned A_BASE(input int unsigned s);
    return s + 1;
  endfunction

  function automatic int unsigned B_BASE(input int unsigned s);
    return 2 * s + 1;
  endfunction

  function automatic int unsigned LOAD_LAST(input int unsigned s);
    return 3 * s;
  endfunction

endpackage

// File: rtl/mm_res_fifo.sv
// Two-entry result FIFO between BRAM read data and the result stream.
// Ports: clk, rst_n, push/din, pop/dout, full, empty.
module mm_res_fifo
  import mm_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [SEC_W-1:0] din,
  input  logic             pop,
  output logic [SEC_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [SEC_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;

  assign dout  = mem[rd_ptr];
  assign full  = (level == 2'd2);
  assign empty = (level == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mm_bridge_host.sv
// Host loader/unloader for the Montgomery multiplier bridge BRAM (port B).
// Ports: clock/reset, operand stream in, result stream out, BRAM B, mm start/done, busy/done.
module mm_bridge_host
  import mm_bridge_pkg::*;
#(
  parameter int s = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [SEC_W-1:0] op_data_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  output logic [SEC_W-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             bram_en_o,
  output logic             bram_we_o,
  output logic [31:0]      bram_addr_o,
  output logic [SEC_W-1:0] bram_din_o,
  input  logic [SEC_W-1:0] bram_dout_i,
  output logic             mm_start_o,
  input  logic             mm_done_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int ADDR_W = $clog2(4 * s);

  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(LOAD_LAST(s));
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(s - 1);
  localparam logic [ADDR_W-1:0] R_BASE = ADDR_W'(RES_BASE);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] wcnt_q;
  logic [ADDR_W-1:0] rcnt_q;
  logic              inflight_q;

  logic              op_hs;
  logic              pop;
  logic              rd_issue;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] addr;

  assign op_ready_o  = (state_q == S_LOAD);
  assign op_hs       = op_ready_o && op_valid_i;
  assign mm_start_o  = (state_q == S_START);
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = !fifo_empty &&
                       ((state_q == S_READ) || (state_q == S_FLUSH));
  assign pop         = res_valid_o && res_ready_i;

  // A read may issue only if its data has a slot once it lands,
  // counting the read already in flight and any pop this cycle.
  assign rd_issue = (state_q == S_READ) &&
                    (inflight_q ? (fifo_empty || pop)
                                : (!fifo_full || pop));

  assign done_o = (state_q == S_FLUSH) && !inflight_q &&
                  (fifo_empty || (pop && !fifo_full));

  always_comb begin
    bram_en_o  = 1'b0;
    bram_we_o  = 1'b0;
    addr       = '0;
    bram_din_o = '0;
    if (op_hs) begin
      bram_en_o  = 1'b1;
      bram_we_o  = 1'b1;
      addr       = wcnt_q;
      bram_din_o = op_data_i;
    end else if (rd_issue) begin
      bram_en_o = 1'b1;
      addr      = R_BASE + rcnt_q;
    end
  end

  assign bram_addr_o = {{(32 - ADDR_W){1'b0}}, addr};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD:  if (op_hs && wcnt_q == W_LAST) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (mm_done_i) state_d = S_READ;
      S_READ:  if (rd_issue && rcnt_q == R_LAST) state_d = S_FLUSH;
      S_FLUSH: if (done_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      if (state_q == S_IDLE && start_i) begin
        wcnt_q <= '0;
      end else if (op_hs) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (state_q == S_WAIT && mm_done_i) begin
        rcnt_q <= '0;
      end else if (rd_issue) begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  mm_res_fifo u_fifo (
    .clk   (clock_i),
    .rst_n (reset_i),
    .push  (inflight_q),
    .din   (bram_dout_i),
    .pop   (pop),
    .dout  (res_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mm_bridge_host.sv
// Directed self-checking bench for mm_bridge_host with s = 4.
// Models the bridge BRAM port B with one-cycle read latency.
module tb_mm_bridge_host;
  import mm_bridge_pkg::*;

  localparam int S = 4;
  localparam int N = 3 * S + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [16:0] op_data;
  logic        op_valid;
  logic        op_ready;
  logic [16:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        bram_en;
  logic        bram_we;
  logic [31:0] bram_addr;
  logic [16:0] bram_din;
  logic [16:0] bram_dout;
  logic        mm_start;
  logic        mm_done;
  logic        busy;
  logic        done;

  mm_bridge_host #(.s(S)) dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .start_i     (start),
    .op_data_i   (op_data),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .res_data_o  (res_data),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .bram_en_o   (bram_en),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_din_o  (bram_din),
    .bram_dout_i (bram_dout),
    .mm_start_o  (mm_start),
    .mm_done_i   (mm_done),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] mem [16];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < S; k++) mem[k+1] <= 17'h1A000 + 17'(k);
    end else if (bram_en && bram_we) begin
      mem[bram_addr[3:0]] <= bram_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (bram_en && !bram_we) begin
      bram_dout <= mem[bram_addr[3:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_op(input bit gaps, input bit spur);
    int k;
    int c;
    k = 0;
    c = 0;
    @(negedge clk);
    start = 1'b1;
    while (k < N && c < 60) begin
      @(negedge clk);
      start    = 1'b0;
      mm_done  = 1'b0;
      op_valid = gaps ? ((c % 2) == 0) : 1'b1;
      op_data  = 17'(k + 1);
      if (spur && k == 5) begin
        start   = 1'b1;
        mm_done = 1'b1;
      end
      #1;
      chk("load_ready", op_ready, 1);
      chk("load_nostart", mm_start, 0);
      if (op_valid) begin
        chk("load_we", {bram_en, bram_we}, 2'b11);
        chk("load_addr", bram_addr, k);
        chk("load_din", bram_din, k + 1);
        k++;
      end else begin
        chk("gap_no_en", bram_en, 0);
      end
      c++;
    end
    if (k < N) chk("load_timeout", k, N);
    @(negedge clk);
    op_valid = 1'b0;
    start    = 1'b0;
    mm_done  = 1'b0;
    #1;
    chk("start_pulse", mm_start, 1);
    chk("start_ready", op_ready, 0);
    @(negedge clk);
    #1;
    chk("start_once", mm_start, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic kick_read();
    @(negedge clk);
    preload = 1'b1;
    mm_done = 1'b1;
    #1;
  endtask

  initial begin
    int base;
    int wbase;
    int idx;
    bit got_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    op_data   = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    mm_done   = 1'b0;
    #2;
    chk("rst_outs",
        {op_ready, res_valid, bram_en, bram_we, mm_start, busy, done}, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_din", bram_din, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain load with spurious start/done mid-load
    wbase = wr_cnt;
    load_op(1'b0, 1'b1);
    chk("load_count", wr_cnt - wbase, N);
    chk("mem_b_last", mem[12], 13);

    // Read-back with sink always ready
    kick_read();
    base = rd_cnt;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      preload   = 1'b0;
      mm_done   = 1'b0;
      res_ready = 1'b1;
      #1;
      if (c < 4) begin
        chk("rd_en", {bram_en, bram_we}, 2'b10);
        chk("rd_addr", bram_addr, 1 + c);
      end else begin
        chk("rd_idle", bram_en, 0);
      end
      chk("rd_valid", res_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("rd_data", res_data, 17'h1A000 + c - 2);
      chk("rd_done", done, (c == 5));
    end
    chk("rd_reads", rd_cnt - base, S);
    chk("rd_idle_busy", busy, 0);

    // Output backpressure
    load_op(1'b0, 1'b0);
    kick_read();
    base = rd_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      preload   = 1'b0;
      mm_done   = 1'b0;
      res_ready = 1'b0;
      #1;
      if (c >= 2) begin
        chk("bp_valid", res_valid, 1);
        chk("bp_hold", res_data, 17'h1A000);
      end
    end
    chk("bp_two_reads", rd_cnt - base, 2);
    idx = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      res_ready = 1'b1;
      #1;
      if (res_valid) begin
        chk("bp_drain", res_data, 17'h1A000 + idx);
        idx++;
      end
      if (done) got_done = 1'b1;
    end
    chk("bp_done", got_done, 1);
    chk("bp_count", idx, S);
    chk("bp_reads", rd_cnt - base, S);

    // Input gaps, then reset mid-WAIT
    wbase = wr_cnt;
    load_op(1'b1, 1'b0);
    chk("gap_count", wr_cnt - wbase, N);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_outs",
        {op_ready, res_valid, bram_en, bram_we, mm_start, busy, done}, 0);
    chk("mrst_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mm_done = 1'b1;
    #1;
    chk("mrst_done_ign", {busy, bram_en}, 0);
    @(negedge clk);
    mm_done = 1'b0;
    #1;
    chk("mrst_idle", {busy, bram_en, res_valid}, 0);
    wbase = wr_cnt;
    load_op(1'b0, 1'b0);
    chk("reload_count", wr_cnt - wbase, N);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mm_bridge_host.md
# mm_bridge_host

Host-side loader/unloader for the Montgomery multiplier's bridge BRAM. It accepts one operand set as a stream of 17-bit sections and writes it into BRAM port B at the addresses the multiplier's top control reads from. It then pulses the multiplier start, waits for done, reads the s result sections back from BRAM and streams them out with valid/ready backpressure. It is the opposite end of the bridge BRAM from the multiplier top.

## Interface
- s, 8: number of 17-bit sections per operand; must match the multiplier instance.
- ADDR_W, $clog2(4*s): BRAM address width (localparam).
- Fixed address map, held in the package:
  - p'_0 at address 0.
  - p at 1..s.
  - a at s+1..2s.
  - b at 2s+1..3s.
  - Result at 1..s; the multiplier overwrites the p region after it has consumed p.

Ports:
- clock_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin one transaction; sampled in IDLE only.
- op_data_i  in  17  operand section.
- op_valid_i  in  1  op_data_i valid.
- op_ready_o  out  1  section accepted when op_valid_i && op_ready_o.
- res_data_o  out  17  result section, least-significant section first.
- res_valid_o  out  1  res_data_o valid.
- res_ready_i  in  1  sink accepts result section.
- bram_en_o  out  1  BRAM port B enable.
- bram_we_o  out  1  BRAM port B write enable.
- bram_addr_o  out  32  zero-extended ADDR_W address.
- bram_din_o  out  17  write data.
- bram_dout_i  in  17  read data, valid one cycle after an enabled read.
- mm_start_o  out  1  one-cycle start pulse to the multiplier.
- mm_done_i  in  1  multiplier done, level or pulse.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the last result section is handed off.

## Operation
- FSM states: IDLE, LOAD, START, WAIT, READ, FLUSH.
- IDLE: all strobes low. On start_i go to LOAD and clear word counter wcnt.
- LOAD:
  - op_ready_o = 1.
  - Each handshake drives bram_en_o = bram_we_o = 1, bram_addr_o = wcnt, bram_din_o = op_data_i combinationally in the same cycle, then increments wcnt.
  - Input order is p'_0, p[0..s-1], a[0..s-1], b[0..s-1]; wcnt equals the address.
  - After handshake 3s+1 (wcnt = 3s) go to START.
- START: mm_start_o = 1 for exactly one cycle, then WAIT.
- WAIT: on mm_done_i = 1 go to READ and clear read counter rcnt. mm_done_i is ignored in every other state.
- READ:
  - Issue a read (bram_en_o = 1, bram_we_o = 0, address 1 + rcnt) only when the output FIFO has a free slot after counting the one read in flight; increment rcnt.
  - Data returned one cycle later is pushed into the FIFO.
  - After s reads are issued go to FLUSH.
- FLUSH: wait until the in-flight read has landed and the FIFO is empty after the last pop, pulse done_o, return to IDLE.
- res_valid_o is high whenever the FIFO is non-empty, in READ and FLUSH. A pop occurs on res_valid_o && res_ready_i.
- Outputs reset to 0: op_ready_o, res_valid_o, res_data_o, all bram_* outputs, mm_start_o, busy_o, done_o. FSM resets to IDLE, counters to 0, FIFO to empty.

## Timing
- Load: 3s+1 cycles minimum, one section per cycle with op_valid_i held high. Each write occurs in the handshake cycle.
- Input stalls: op_valid_i low pauses the load. No BRAM write occurs and wcnt holds.
- START: entered the cycle after the last handshake; mm_start_o is high one cycle.
- First result section: res_valid_o rises 2 cycles after READ entry (read issue, data return, then FIFO output visible).
- Throughput with res_ready_i held high: one section per cycle. Total from READ entry to done_o is s+2 cycles.
- Output backpressure: with res_ready_i low, the FIFO fills to 2 and reads stop. res_data_o is stable while res_valid_o && !res_ready_i. No section is lost or duplicated.
- start_i outside IDLE: ignored.
- op_valid_i outside LOAD: op_ready_o low, no write.
- Simultaneous FIFO push and pop: allowed; occupancy is unchanged.
- reset_i low at any time: immediate return to IDLE with reset values. BRAM contents are left untouched.

## Structure
- Package mm_bridge_pkg holds:
  - the state enum;
  - the address constants, as functions of s: P_PRIME_0_ADDR, P_BASE, A_BASE, B_BASE, RES_BASE;
  - the section width SEC_W = 17.
- One sub-module: mm_res_fifo, a 2-entry synchronous FIFO with push/pop/full/empty and async active-low reset.

## Test plan
- Load: s = 4, operand words 0x00001..0x0000D with op_valid_i held high. Expect 13 writes at addresses 0..12 with matching data in consecutive cycles, then one mm_start_o pulse.
- Read-back: BRAM model preloaded with 0x1A000..0x1A003 at addresses 1..4, then mm_done_i pulsed. Expect res_data_o 0x1A000..0x1A003 on 4 consecutive cycles and a done_o pulse in the cycle of the last handshake.
- Output backpressure: res_ready_i low for 10 cycles after READ entry. Expect exactly 2 reads issued, res_data_o held at 0x1A000, then an in-order complete drain once res_ready_i goes high.
- Input gaps: op_valid_i toggling every cycle. Expect a write only on handshake cycles, 13 writes total, and addresses with no gaps.
- Reset mid-WAIT: reset_i low for 1 cycle. Expect all outputs 0 and IDLE. A subsequent mm_done_i is ignored, and a new start_i loads correctly from address 0.
- Spurious inputs: start_i and mm_done_i asserted during LOAD. Expect no state change and no mm_start_o.
